// File: rtl/dff_chk_pkg.sv
// Shared types and defaults for the DFF stream checker.
// Optional build macro: DFF_CHK_HALT_ON_FAIL_EN.
package dff_chk_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_NUM_CHECKS = 10;
  localparam int DEF_LATENCY    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dff_chk_delay.sv
// LATENCY-deep shift register that re-times d_tap into
// the expected Q value; synchronous active-low clear.
module dff_chk_delay #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [LATENCY];
  logic [WIDTH-1:0] sr_d [LATENCY];

  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sr_q <= '{default: '0};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[LATENCY-1];

endmodule

// File: rtl/dff_stream_checker.sv
// Self-check monitor comparing delayed D against Q of a DFF.
// Define DFF_CHK_HALT_ON_FAIL_EN to stop a run at the first mismatch.
module dff_stream_checker
  import dff_chk_pkg::*;
#(
  parameter int  WIDTH      = DEF_WIDTH,
  parameter int  NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int  LATENCY    = DEF_LATENCY,
  localparam int CNT_W      = cnt_w(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d_tap,
  input  logic [WIDTH-1:0] q_tap,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_got
);

`ifdef DFF_CHK_HALT_ON_FAIL_EN
  localparam bit HaltOnFail = 1'b1;
`else
  localparam bit HaltOnFail = 1'b0;
`endif

  localparam int PW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  chk_state_e       state_q, state_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [WIDTH-1:0] ffe_q, ffe_d;
  logic [WIDTH-1:0] ffg_q, ffg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ap_q, ap_d;

  logic [WIDTH-1:0] exp_v;
  logic             match;
  logic             start_run;
  logic             prime_last;
  logic             idx_last;

  dff_chk_delay #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk   (clk),
    .clr_n (rst),
    .din   (d_tap),
    .dout  (exp_v)
  );

  // An unknown q_tap falls through to the mismatch branch below.
  assign match      = (exp_v == q_tap);
  assign start_run  = start && (state_q == IDLE || state_q == DONE);
  assign prime_last = (prime_q == PW'(LATENCY - 1));
  assign idx_last   = (idx_q == CNT_W'(NUM_CHECKS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      prime_q <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ffi_q   <= '0;
      ffe_q   <= '0;
      ffg_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffi_q   <= ffi_d;
      ffe_q   <= ffe_d;
      ffg_q   <= ffg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ap_q    <= ap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_run) state_d = PRIME;
      end
      PRIME: begin
        if (prime_last) state_d = CHECK;
      end
      CHECK: begin
        if (match) begin
          if (idx_last) state_d = DONE;
        end else if (idx_last || HaltOnFail) begin
          state_d = DONE;
        end
      end
    endcase
  end

  always_comb begin
    prime_d = prime_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffi_d   = ffi_q;
    ffe_d   = ffe_q;
    ffg_d   = ffg_q;
    if (start_run) begin
      prime_d = '0;
      idx_d   = '0;
      pass_d  = '0;
      fail_d  = '0;
      ffi_d   = '0;
      ffe_d   = '0;
      ffg_d   = '0;
    end else if (state_q == PRIME) begin
      prime_d = prime_q + 1'b1;
    end else if (state_q == CHECK) begin
      idx_d = idx_q + 1'b1;
      if (match) begin
        pass_d = pass_q + 1'b1;
      end else begin
        fail_d = fail_q + 1'b1;
        if (fail_q == '0) begin
          ffi_d = idx_q;
          ffe_d = exp_v;
          ffg_d = q_tap;
        end
      end
    end
    busy_d = (state_d == PRIME) || (state_d == CHECK);
    done_d = (state_d == DONE);
    ap_d   = (state_d == DONE) && (fail_d == '0);
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign all_pass       = ap_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_exp = ffe_q;
  assign first_fail_got = ffg_q;

endmodule

// File: doc/dff_stream_checker.md
Name: dff_stream_checker

Overview:
- Hardware self-check stage downstream of the 4-bit DFF under test (`clk`, `rst`, `D`, `Q`).
- Taps the DFF's `D` input and `Q` output, delays `D` by the DFF latency and compares against `Q` every cycle.
- Accumulates pass/fail counts over a programmed number of checks, then reports a verdict.
- Replaces per-cycle `$strobe` checking with a synthesizable monitor usable on FPGA or in regression.

Parameters:
- WIDTH, 4: data width of the DFF under check.
- NUM_CHECKS, 10: number of compares per run; at least 1.
- LATENCY, 1: register stages between D and Q; at least 1.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run when the block is idle or done.
- d_tap  input  WIDTH  DFF `D` input as driven into the DUT.
- q_tap  input  WIDTH  DFF `Q` output.
- busy  output  1  high during PRIME and CHECK.
- done  output  1  high in DONE until the next start or reset.
- all_pass  output  1  valid when done; 1 if fail_cnt==0.
- pass_cnt  output  CNT_W  number of matching compares; CNT_W=$clog2(NUM_CHECKS+1).
- fail_cnt  output  CNT_W  number of mismatching compares.
- first_fail_idx  output  CNT_W  compare index (0-based) of the first mismatch; 0 if there is none.
- first_fail_exp  output  WIDTH  expected value at the first mismatch.
- first_fail_got  output  WIDTH  `q_tap` value at the first mismatch.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, and the delay line clears to 0.
  - Reset has priority over everything, including mid-run; a run interrupted by reset is discarded.
- Delay line:
  - LATENCY-deep shift register of `d_tap`, shifting every cycle in every state.
  - exp = oldest entry.
- FSM states:
  - IDLE: start=1 → PRIME. Clears the counters, first_fail_* and done on that transition.
  - PRIME: waits LATENCY cycles so the delay line holds run data; prime counter counts 0..LATENCY-1, then → CHECK.
  - CHECK: every cycle compares exp against q_tap.
    - On a match, pass_cnt increments.
    - On a mismatch, fail_cnt increments. On the first mismatch only, it captures first_fail_idx = current compare index, first_fail_exp and first_fail_got.
    - After compare index NUM_CHECKS-1 → DONE.
  - DONE: done=1; all_pass=(fail_cnt==0). Counts hold. start=1 → PRIME with the same clearing as from IDLE.
- start during PRIME or CHECK is ignored.
- Timing:
  - busy is a registered output, high from the cycle after start until the cycle DONE is entered.
  - Total run length is LATENCY + NUM_CHECKS cycles from start to done.
- Counter invariant: pass_cnt+fail_cnt == compares performed, never exceeding NUM_CHECKS; no wrap is possible given CNT_W.
- X handling: an X or Z on q_tap is counted as a fail (use `!==` in simulation assertions only; RTL compare is `!=`).

Optional Feature:
- Macro: DFF_CHK_HALT_ON_FAIL_EN.
- Defined: the first mismatch in CHECK moves directly to DONE after capturing first_fail_*. fail_cnt ends at 1, all_pass=0, and pass_cnt holds the passes before the failure.
- Undefined: all NUM_CHECKS compares always run.

Decomposition:
- Package dff_chk_pkg holds:
  - state enum `chk_state_e` {IDLE, PRIME, CHECK, DONE}, 2-bit;
  - function `cnt_w(n)` returning $clog2(n+1);
  - default localparams for WIDTH, NUM_CHECKS and LATENCY.
- One sub-module, dff_chk_delay: parameterized WIDTH/LATENCY shift register with a synchronous active-low clear. Top-level holds the FSM, counters and capture registers.

Test Plan:
- Hook to a good 4-bit DFF with random d_tap; pulse start → done after 11 cycles, pass_cnt=10, fail_cnt=0, all_pass=1.
- Force q_tap to 4'hF while d_tap=4'h3 on compare index 4 only → fail_cnt=1, pass_cnt=9, first_fail_idx=4, first_fail_exp=4'h3, first_fail_got=4'hF, all_pass=0.
- Assert rst=0 for one cycle mid-CHECK at index 6 → all outputs 0, state IDLE; a new start gives a clean full run with pass_cnt=10.
- Pulse start again during CHECK → ignored, run length unchanged. Pulse start in DONE → counts clear and a new run completes.
- LATENCY=2 with a two-stage DUT → PRIME lasts 2 cycles, pass_cnt=10. The same DUT with LATENCY=1 → fail_cnt>0.
- With DFF_CHK_HALT_ON_FAIL_EN and mismatches at indices 2 and 5 → done right after index 2, fail_cnt=1, pass_cnt=2, first_fail_idx=2.
